// File: rtl/alu_sub_mp.sv
// Multi-precision sequential subtractor: WIDTH-bit operands, CHUNK bits per cycle, LSB slice first.
// ARM-style flags (carry = no borrow) with SUB, SBC, CMP (flags only) and RSB modes.
module alu_sub_mp #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [1:0] M_SUB = 2'b00;
    localparam logic [1:0] M_SBC = 2'b01;
    localparam logic [1:0] M_CMP = 2'b10;
    localparam logic [1:0] M_RSB = 2'b11;

    generate
        if ((NCHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("alu_sub_mp: WIDTH must be a positive integer multiple of CHUNK");
        end
    endgenerate

    // Control and architecturally visible state.
    logic [0:0]       state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    // Datapath working registers.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic             cmp_q, cmp_d;

    logic [CHUNK-1:0] a_k, b_k;
    logic [CHUNK:0]   sum_k;
    int               lo;

    // One CHUNK+1-bit add per cycle: A_k + ~B_k + chained carry.
    always_comb begin
        lo    = int'(k_q) * CHUNK;
        a_k   = a_q[lo +: CHUNK];
        b_k   = b_q[lo +: CHUNK];
        sum_k = {1'b0, a_k} + {1'b0, ~b_k} + {{CHUNK{1'b0}}, c_q};
    end

    // NOTE: combinational next-state logic uses blocking assignments with every
    // target defaulted first, so r_d can be read back after the slice update
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        k_d     = k_q;
        c_d     = c_q;
        cmp_d   = cmp_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    cmp_d   = (mode == M_CMP);
                    c_d     = (mode == M_SBC) ? carry_in : 1'b1;
                    if (mode == M_RSB) begin
                        a_d = operand2;
                        b_d = operand1;
                    end else begin
                        a_d = operand1;
                        b_d = operand2;
                    end
                end
            end

            S_RUN: begin
                r_d[lo +: CHUNK] = sum_k[CHUNK-1:0];
                c_d              = sum_k[CHUNK];
                k_d              = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!cmp_q) begin
                        dout_d = r_d;
                    end
                    carry_d = sum_k[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (r_d == '0);
                    neg_d   = r_d[WIDTH-1];
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    // NOTE: working registers are fully reloaded on acceptance before they are
    // read, so they carry no reset and stay plain flops.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        r_q   <= r_d;
        k_q   <= k_d;
        c_q   <= c_d;
        cmp_q <= cmp_d;
    end

    assign busy  = (state_q == S_RUN);
    assign done  = done_q;
    assign dout  = dout_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
    assign neg   = neg_q;

endmodule

// File: tb/tb_alu_sub_mp.sv
// Directed-vector and soak bench for alu_sub_mp: a 64/16 instance and a 16/16 instance.
module tb_alu_sub_mp;

    localparam logic [1:0] M_SUB = 2'b00;
    localparam logic [1:0] M_SBC = 2'b01;
    localparam logic [1:0] M_CMP = 2'b10;
    localparam logic [1:0] M_RSB = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        carry_in;

    logic        start_w, busy_w, done_w, carry_w, ovf_w, zero_w, neg_w;
    logic [63:0] op1_w, op2_w, dout_w;

    logic        start_n, busy_n, done_n, carry_n, ovf_n, zero_n, neg_n;
    logic [15:0] op1_n, op2_n, dout_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sub_mp #(.WIDTH(64), .CHUNK(16)) u_dut_w (
        .clk(clk), .reset(reset), .start(start_w), .mode(mode), .carry_in(carry_in),
        .operand1(op1_w), .operand2(op2_w), .busy(busy_w), .done(done_w), .dout(dout_w),
        .carry(carry_w), .ovf(ovf_w), .zero(zero_w), .neg(neg_w)
    );

    alu_sub_mp #(.WIDTH(16), .CHUNK(16)) u_dut_n (
        .clk(clk), .reset(reset), .start(start_n), .mode(mode), .carry_in(carry_in),
        .operand1(op1_n), .operand2(op2_n), .busy(busy_n), .done(done_n), .dout(dout_n),
        .carry(carry_n), .ovf(ovf_n), .zero(zero_n), .neg(neg_n)
    );

    typedef struct {
        string       name;
        logic        sel;      // 1 = 16-bit instance
        logic [1:0]  mode;
        logic        cin;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_dout;
        logic [3:0]  exp_cvzn;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(input logic sel);
        return sel ? busy_n : busy_w;
    endfunction

    function automatic logic done_of(input logic sel);
        return sel ? done_n : done_w;
    endfunction

    function automatic logic [63:0] dout_of(input logic sel);
        return sel ? {48'h0, dout_n} : dout_w;
    endfunction

    function automatic logic [3:0] flags_of(input logic sel);
        return sel ? {carry_n, ovf_n, zero_n, neg_n} : {carry_w, ovf_w, zero_w, neg_w};
    endfunction

    // Waits (bounded) for done, counting negedges and busy-high negedges.
    task automatic wait_done(input logic sel, output int lat, output int bcnt);
        logic got;
        got  = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            start_w = 1'b0;
            start_n = 1'b0;
            lat++;
            if (busy_of(sel)) bcnt++;
            got = done_of(sel);
        end
        check("done_seen", got, 1'b1);
    endtask

    task automatic run_op(input logic sel, input logic [1:0] m, input logic cin,
                          input logic [63:0] a, input logic [63:0] b,
                          output int lat, output int bcnt);
        mode     = m;
        carry_in = cin;
        if (sel) begin
            op1_n   = a[15:0];
            op2_n   = b[15:0];
            start_n = 1'b1;
        end else begin
            op1_w   = a;
            op2_w   = b;
            start_w = 1'b1;
        end
        wait_done(sel, lat, bcnt);
    endtask

    task automatic add(input string name, input logic sel, input logic [1:0] m, input logic cin,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ed, input logic [3:0] ef);
        vec_t v;
        v.name = name; v.sel = sel; v.mode = m; v.cin = cin;
        v.a = a; v.b = b; v.exp_dout = ed; v.exp_cvzn = ef;
        vq.push_back(v);
    endtask

    // Independent model: wide subtraction for value/carry, flag formulas from the result.
    task automatic model(input logic [1:0] m, input logic cin, input logic [63:0] o1,
                         input logic [63:0] o2, output logic [63:0] r, output logic [3:0] f);
        logic [63:0] a, b;
        logic [65:0] diff;
        logic        bw;
        a    = (m == M_RSB) ? o2 : o1;
        b    = (m == M_RSB) ? o1 : o2;
        bw   = (m == M_SBC) ? !cin : 1'b0;
        diff = {2'b00, a} - {2'b00, b} - {65'h0, bw};
        r    = diff[63:0];
        f    = {!diff[65], (a[63] != b[63]) && (r[63] != a[63]), r == 64'h0, r[63]};
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, bcnt, dcnt, t0, t1, t2;
        logic [63:0] mdout, r;
        logic [3:0]  f;
        logic [1:0]  m;
        logic        cin;
        logic [63:0] a, b;

        reset = 1'b1; start_w = 1'b0; start_n = 1'b0;
        mode = M_SUB; carry_in = 1'b0;
        op1_w = '0; op2_w = '0; op1_n = '0; op2_n = '0;
        repeat (3) @(negedge clk);
        check("rst_w_busy_done", {busy_w, done_w}, 2'b00);
        check("rst_w_dout", dout_w, 64'h0);
        check("rst_w_flags", {carry_w, ovf_w, zero_w, neg_w}, 4'h0);
        check("rst_n_all", {busy_n, done_n, dout_n, carry_n, ovf_n, zero_n, neg_n}, 22'h0);
        reset = 1'b0;
        @(negedge clk);

        // flags order {carry, ovf, zero, neg}
        add("n_sub_1_1",      1, M_SUB, 0, 64'h1,    64'h1,    64'h0,    4'b1010);
        add("n_sub_8000",     1, M_SUB, 0, 64'h8000, 64'h2000, 64'h6000, 4'b1100);
        add("n_sub_ffff",     1, M_SUB, 0, 64'hFFFF, 64'hFFFF, 64'h0,    4'b1010);
        add("n_rsb_ovf",      1, M_RSB, 0, 64'h0001, 64'h8000, 64'h7FFF, 4'b1100);
        add("w_sub_boundary", 0, M_SUB, 0, 64'h0000_0001_0000_0000, 64'h1,
            64'h0000_0000_FFFF_FFFF, 4'b1000);
        add("w_sub_0_1",      0, M_SUB, 0, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
        add("w_sub_min_1",    0, M_SUB, 0, 64'h8000_0000_0000_0000, 64'h1,
            64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
        add("w_sbc_5_3",      0, M_SBC, 0, 64'h5, 64'h3, 64'h1, 4'b1000);
        add("w_sbc_0_0",      0, M_SBC, 0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
        add("w_sbc_cin1",     0, M_SBC, 1, 64'h9, 64'h9, 64'h0, 4'b1010);
        add("w_rsb_3_10",     0, M_RSB, 0, 64'h3, 64'hA, 64'h7, 4'b1000);
        add("w_sub_1235",     0, M_SUB, 0, 64'h1235, 64'h1, 64'h1234, 4'b1000);
        add("w_cmp_5_7",      0, M_CMP, 0, 64'h5, 64'h7, 64'h1234, 4'b0001);
        add("w_cmp_eq",       0, M_CMP, 0, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001,
            64'h1234, 4'b1010);

        foreach (vq[i]) begin
            run_op(vq[i].sel, vq[i].mode, vq[i].cin, vq[i].a, vq[i].b, lat, bcnt);
            check({vq[i].name, "_latency"}, 64'(lat), vq[i].sel ? 64'd2 : 64'd5);
            check({vq[i].name, "_busy_cycles"}, 64'(bcnt), vq[i].sel ? 64'd1 : 64'd4);
            check({vq[i].name, "_dout"}, dout_of(vq[i].sel), vq[i].exp_dout);
            check({vq[i].name, "_flags"}, 64'(flags_of(vq[i].sel)), 64'(vq[i].exp_cvzn));
            @(negedge clk);
            check({vq[i].name, "_done_width"}, done_of(vq[i].sel), 1'b0);
        end

        // start pulsed while busy is ignored
        mode = M_SUB; op1_w = 64'd10; op2_w = 64'd3; start_w = 1'b1;
        @(negedge clk); start_w = 1'b0;
        @(negedge clk); start_w = 1'b1; op1_w = 64'd100; op2_w = 64'd1;
        @(negedge clk); start_w = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_w) dcnt++;
        end
        check("busy_start_done_count", 64'(dcnt), 64'd1);
        check("busy_start_dout", dout_w, 64'd7);

        // start held high: completions every NCHUNK+1 cycles
        mode = M_SUB; op1_w = 64'd50; op2_w = 64'd8; start_w = 1'b1;
        t0 = -1; t1 = -1; t2 = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done_w) begin
                if (t0 < 0) t0 = i;
                else if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end
        end
        start_w = 1'b0;
        check("held_first_done", 64'(t0), 64'd5);
        check("held_gap1", 64'(t1 - t0), 64'd5);
        check("held_gap2", 64'(t2 - t1), 64'd5);
        repeat (8) @(negedge clk);
        check("held_dout", dout_w, 64'd42);

        // operands, mode and carry_in changed during RUN have no effect
        mode = M_SUB; carry_in = 1'b0; op1_w = 64'd1000; op2_w = 64'd1; start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0; op1_w = 64'hFFFF_FFFF_FFFF_FFFF; op2_w = 64'd55; mode = M_RSB;
        wait_done(1'b0, lat, bcnt);
        check("opchange_dout", dout_w, 64'd999);
        check("opchange_flags", {carry_w, ovf_w, zero_w, neg_w}, 4'b1000);
        @(negedge clk);

        // reset in the 2nd RUN cycle aborts
        mode = M_SUB; op1_w = 64'h1234_5678_9ABC_DEF0; op2_w = 64'd1; start_w = 1'b1;
        @(negedge clk); start_w = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort_busy_done", {busy_w, done_w}, 2'b00);
        check("abort_dout", dout_w, 64'h0);
        check("abort_flags", {carry_w, ovf_w, zero_w, neg_w}, 4'h0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_w) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);
        run_op(1'b0, M_SUB, 1'b0, 64'd20, 64'd5, lat, bcnt);
        check("after_abort_latency", 64'(lat), 64'd5);
        check("after_abort_dout", dout_w, 64'd15);
        mdout = 64'd15;

        // random soak against the reference model, back-to-back issue
        for (int i = 0; i < 2000; i++) begin
            m   = 2'($urandom_range(0, 3));
            cin = 1'($urandom_range(0, 1));
            a   = rnd64();
            b   = rnd64();
            run_op(1'b0, m, cin, a, b, lat, bcnt);
            model(m, cin, a, b, r, f);
            if (m != M_CMP) mdout = r;
            check("soak_dout", dout_w, mdout);
            check("soak_flags", {carry_w, ovf_w, zero_w, neg_w}, f);
            if (m == M_SUB || m == M_CMP)
                check("soak_ge_identity", neg_w == ovf_w, $signed(a) >= $signed(b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
